// File: rtl/serial_adder16.sv
// serial_adder16 -- bit-serial adder, LSB first, one bit per clock.
//
// A WIDTH-bit addition takes WIDTH cycles in RUN. The sum is then presented
// with a single-cycle done pulse. The one-bit full-adder cell is built only
// from the Xor/And/Or gate cells, which are defined at the top of this file.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request a new addition (accepted in IDLE or DONE)
//   a, b   WIDTH-bit operands, captured on the accepting edge
//   cin    carry-in, captured on the accepting edge
//   busy   high while an addition is running
//   done   one-cycle pulse: sum/cout just updated
//   sum    result of the last completed addition
//   cout   carry-out of the last completed addition

// Gate cell: 2-input XOR
module Xor (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a ^ b;
endmodule

// Gate cell: 2-input AND
module And (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a & b;
endmodule

// Gate cell: 2-input OR
module Or (
   input  logic a,
   input  logic b,
   output logic y
);
   assign y = a | b;
endmodule

module serial_adder16 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] ra, rb, rs;
   logic             c;
   logic [CW-1:0]    cnt;

   // Full-adder cell built from the gate library
   logic p, g, t, s, c_next;

   Xor u_x_p (.a(ra[0]), .b(rb[0]), .y(p));
   Xor u_x_s (.a(p),     .b(c),     .y(s));
   And u_a_g (.a(ra[0]), .b(rb[0]), .y(g));
   And u_a_t (.a(p),     .b(c),     .y(t));
   Or  u_o_c (.a(g),     .b(t),     .y(c_next));

   // Result register after this cycle's bit shifts in at the MSB end;
   // on the last bit this is the complete sum.
   logic [WIDTH-1:0] rs_next;
   assign rs_next = {s, rs[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ra    <= '0;
         rb    <= '0;
         rs    <= '0;
         c     <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         case (state)
            // DONE behaves like IDLE, apart from the done pulse it presents
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  ra    <= a;
                  rb    <= b;
                  c     <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               // start is deliberately ignored here
               ra  <= ra >> 1;
               rb  <= rb >> 1;
               c   <= c_next;
               rs  <= rs_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  sum   <= rs_next;
                  cout  <= c_next;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder16.sv
module tb_serial_adder16;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int total = 0;
   int bad   = 0;

   serial_adder16 #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One addition from IDLE: checks latency, busy length, result, single pulse.
   task automatic do_add(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                         input logic [W-1:0] es, input logic ec, input string name);
      int lat;
      int bc;
      @(negedge clk);
      a = va; b = vb; cin = vc; start = 1'b1;
      @(negedge clk);              // edge E0 has accepted
      start = 1'b0; a = '0; b = '0; cin = 1'b0;
      lat = 0; bc = 0;
      while (!done && lat < 40) begin
         if (busy) bc++;
         @(negedge clk);
         lat++;
      end
      chk({name, " latency"}, lat, 16);
      chk({name, " busy_cycles"}, bc, 16);
      chk({name, " sum"}, sum, es);
      chk({name, " cout"}, cout, ec);
      chk({name, " busy_at_done"}, busy, 0);
      @(negedge clk);
      chk({name, " done_single"}, done, 0);
   endtask

   vec_t vecs[7];

   initial begin
      int ndone;
      int dcyc;
      int d1, d2;
      logic [W-1:0] s1, s2;
      logic c1, c2;

      vecs[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
      vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[5] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0};
      vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};

      // Reset state, with start asserted during reset
      start = 1'b1; a = 16'h1111; b = 16'h2222;
      repeat (3) @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst sum", sum, 0);
      chk("rst cout", cout, 0);
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle busy", busy, 0);

      for (int i = 0; i < 7; i++)
         do_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
                $sformatf("vec%0d", i));

      // Ignored start during RUN
      @(negedge clk);
      a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0; dcyc = -1; s1 = '0; c1 = 1'b0;
      for (int k = 0; k < 45; k++) begin
         if (k == 5) begin a = 16'hAAAA; b = 16'h5555; start = 1'b1; end
         if (k == 6) begin start = 1'b0; a = '0; b = '0; end
         if (done) begin ndone++; dcyc = k; s1 = sum; c1 = cout; end
         @(negedge clk);
      end
      chk("ign done_count", ndone, 1);
      chk("ign done_cycle", dcyc, 16);
      chk("ign sum", s1, 16'h0100);
      chk("ign cout", c1, 0);
      chk("ign idle", busy, 0);

      // Back-to-back with start held
      a = 16'h8000; b = 16'h8000; cin = 1'b0; start = 1'b1;
      @(negedge clk);              // first accepted
      a = 16'h0003; b = 16'h0004;
      d1 = -1; d2 = -1; s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
      for (int k = 0; k < 45; k++) begin
         if (k == 17) start = 1'b0;   // second accepted on edge 17
         if (done) begin
            if (d1 < 0) begin d1 = k; s1 = sum; c1 = cout; end
            else if (d2 < 0) begin d2 = k; s2 = sum; c2 = cout; end
         end
         @(negedge clk);
      end
      chk("b2b done1_cycle", d1, 16);
      chk("b2b done2_cycle", d2, 33);
      chk("b2b sum1", s1, 16'h0000);
      chk("b2b cout1", c1, 1);
      chk("b2b sum2", s2, 16'h0007);
      chk("b2b cout2", c2, 0);

      // Mid-run reset
      a = 16'h7FFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("mrr busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mrr busy", busy, 0);
      chk("mrr done", done, 0);
      chk("mrr sum", sum, 0);
      chk("mrr cout", cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 20; k++) begin
         if (done || busy) ndone++;
         @(negedge clk);
      end
      chk("mrr no_activity", ndone, 0);
      do_add(16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
